// File: rtl/video_dma_writer.sv
// Video DMA writer: stages a pixel beat stream in a small FIFO and hands it, one beat
// at a time, to an AXI write engine with incrementing byte addresses.
module video_dma_writer #(
    parameter int unsigned LOWRISC_AXI_DATA_WIDTH = 64,
    parameter int unsigned VIDEOMEM_SIZE          = 18,
    parameter int unsigned FIFO_DEPTH             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [VIDEOMEM_SIZE-1:0]          base_addr,
    input  logic [15:0]                       beat_count,
    input  logic                              in_valid,
    input  logic [LOWRISC_AXI_DATA_WIDTH-1:0] in_data,
    output logic                              in_ready,
    output logic                              data_avail,
    output logic [VIDEOMEM_SIZE-1:0]          addr,
    output logic [LOWRISC_AXI_DATA_WIDTH-1:0] data,
    output logic                              final_packet,
    input  logic                              wr_done,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BeatBytes = LOWRISC_AXI_DATA_WIDTH / 8;

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   occ_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StFinish
    } state_e;

    state_e                            state_q, state_d;
    logic [VIDEOMEM_SIZE-1:0]          base_q, base_d;
    logic [15:0]                       count_q, count_d;
    logic [15:0]                       accepted_cnt_q, accepted_cnt_d;
    logic [15:0]                       issued_cnt_q, issued_cnt_d;

    logic [LOWRISC_AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [LOWRISC_AXI_DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    ptr_t                              wr_ptr_q, wr_ptr_d;
    ptr_t                              rd_ptr_q, rd_ptr_d;
    occ_t                              occ_q, occ_d;

    logic                              data_avail_q, data_avail_d;
    logic [VIDEOMEM_SIZE-1:0]          addr_q, addr_d;
    logic [LOWRISC_AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic                              final_q, final_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (occ_q == occ_t'(FIFO_DEPTH));
    assign fifo_empty = (occ_q == '0);

    // Once every beat of the transfer has been accepted, surplus stream beats stay stalled.
    assign in_ready = busy_q && !fifo_full && (accepted_cnt_q != count_q);

    assign push = in_valid && in_ready;
    assign pop  = (state_q == StIssue) && wr_done;

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        count_d        = count_q;
        accepted_cnt_d = accepted_cnt_q;
        issued_cnt_d   = issued_cnt_q;
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        data_avail_d   = data_avail_q;
        addr_d         = addr_q;
        data_d         = data_q;
        final_d        = final_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + ptr_t'(1);
            accepted_cnt_d  = accepted_cnt_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d         = base_addr;
                    count_d        = beat_count;
                    accepted_cnt_d = '0;
                    issued_cnt_d   = '0;
                    wr_ptr_d       = '0;
                    rd_ptr_d       = '0;
                    occ_d          = '0;
                    state_d        = (beat_count == 16'd0) ? StFinish : StFetch;
                end
            end
            StFetch: begin
                // Request fields are captured once here so they stay stable through ISSUE.
                if (!fifo_empty) begin
                    state_d      = StIssue;
                    data_avail_d = 1'b1;
                    addr_d       = base_q + VIDEOMEM_SIZE'(32'(issued_cnt_q) * BeatBytes);
                    data_d       = mem_q[rd_ptr_q];
                    final_d      = (issued_cnt_q == count_q - 16'd1);
                end
            end
            StIssue: begin
                if (wr_done) begin
                    issued_cnt_d = issued_cnt_q + 16'd1;
                    data_avail_d = 1'b0;
                    final_d      = 1'b0;
                    state_d      = final_q ? StFinish : StFetch;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            base_q         <= '0;
            count_q        <= '0;
            accepted_cnt_q <= '0;
            issued_cnt_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            data_avail_q   <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            final_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            count_q        <= count_d;
            accepted_cnt_q <= accepted_cnt_d;
            issued_cnt_q   <= issued_cnt_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            data_avail_q   <= data_avail_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            final_q        <= final_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign data_avail   = data_avail_q;
    assign addr         = addr_q;
    assign data         = data_q;
    assign final_packet = final_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_video_dma_writer.sv
// Directed bench for video_dma_writer: table of whole transfers plus hand-written
// sequences for back-pressure, zero-length, and mid-transfer reset.
module tb_video_dma_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [17:0] base_addr;
    logic [15:0] beat_count;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        data_avail;
    logic [17:0] addr;
    logic [63:0] data;
    logic        final_packet;
    logic        wr_done;
    logic        busy;
    logic        done;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  tag;

    video_dma_writer #(
        .LOWRISC_AXI_DATA_WIDTH(64),
        .VIDEOMEM_SIZE         (18),
        .FIFO_DEPTH            (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .beat_count  (beat_count),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .data_avail  (data_avail),
        .addr        (addr),
        .data        (data),
        .final_packet(final_packet),
        .wr_done     (wr_done),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] base;
        logic [15:0] cnt;
        int          dly;
        int          poke;
        int          stray;
        logic [17:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [63:0] pat(input int i);
        return {tag, 24'hBEEF00, 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one transfer with an always-valid stream; wr_done follows each request
    // after first_dly (first request) or dly cycles. poke/stray inject an extra start
    // or a wr_done outside ISSUE at the given loop cycle.
    task automatic run_xfer(input logic [17:0] b, input logic [15:0] n, input int dly,
                            input int first_dly, input int poke, input int stray,
                            output int n_req, output int n_done, output int acc_first,
                            output logic rdy_before, output logic rdy_after,
                            output logic [17:0] last_addr);
        int          sent;
        int          age;
        logic        pv;
        logic        pr;
        logic        pwd;
        logic        fin;
        logic        first_gap;
        logic [17:0] exp_a;
        sent = 0; age = -1; n_req = 0; n_done = 0; acc_first = -1;
        rdy_before = 1'b0; rdy_after = 1'b0; last_addr = '0;
        pwd = 1'b0; fin = 1'b0; first_gap = 1'b0;
        tag = tag + 8'd1;
        base_addr = b; beat_count = n; start = 1'b1; in_valid = 1'b1; in_data = pat(0);
        pv = 1'b1; pr = in_ready;
        @(posedge clk); #1;
        base_addr = 18'h15555; beat_count = 16'hFFFF;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (pv && pr) sent++;
            start = 1'b0;
            wr_done = 1'b0;
            if (pwd) begin
                chk("avail_gap", data_avail, 0);
                if (first_gap) begin
                    rdy_after = in_ready;
                    first_gap = 1'b0;
                end
            end
            if (done) begin
                n_done++;
                fin = 1'b1;
            end
            if (data_avail) begin
                exp_a = b + 18'(n_req * 8);
                if (age < 0) begin
                    age = 0;
                    chk("addr", addr, exp_a);
                    chk("data", data, pat(n_req));
                    chk("final", final_packet, (n_req == int'(n) - 1));
                end else begin
                    age++;
                end
                if (age == ((n_req == 0) ? first_dly : dly)) begin
                    wr_done = 1'b1;
                    chk("addr_hold", addr, exp_a);
                    chk("data_hold", data, pat(n_req));
                    if (n_req == 0) begin
                        acc_first  = sent;
                        rdy_before = in_ready;
                        first_gap  = 1'b1;
                    end
                    last_addr = addr;
                    n_req++;
                    age = -1;
                end
            end
            pwd = wr_done;
            if (cyc == stray && !data_avail) wr_done = 1'b1;
            if (cyc == poke) begin
                start = 1'b1; base_addr = 18'h30000; beat_count = 16'd9;
            end
            in_data = pat(sent);
            pv = in_valid; pr = in_ready;
            @(posedge clk); #1;
        end
        start = 1'b0; wr_done = 1'b0; in_valid = 1'b0;
        chk("xfer_finished", fin, 1);
        chk("accepted_beats", sent, n);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_data_avail"}, data_avail, 0);
        chk({pfx, "_addr"}, addr, 0);
        chk({pfx, "_data"}, data, 0);
        chk({pfx, "_final"}, final_packet, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
    endtask

    initial begin
        int          n_req;
        int          n_done;
        int          acc_first;
        logic        rdy_before;
        logic        rdy_after;
        logic [17:0] last_addr;
        int          reqs;
        logic        found;
        logic        saw_avail;
        logic        saw_ready;
        int          dones;

        n_cmp = 0; n_bad = 0; tag = 8'h00;
        rst = 1'b1; start = 1'b0; base_addr = '0; beat_count = '0;
        in_valid = 1'b0; in_data = '0; wr_done = 1'b0;

        vecs[0] = '{base: 18'h00100, cnt: 16'd3, dly: 2, poke: -1, stray: -1, exp_last: 18'h00110};
        vecs[1] = '{base: 18'h3FFF8, cnt: 16'd2, dly: 2, poke: -1, stray: -1, exp_last: 18'h00000};
        vecs[2] = '{base: 18'h02000, cnt: 16'd1, dly: 0, poke: -1, stray: -1, exp_last: 18'h02000};
        vecs[3] = '{base: 18'h00000, cnt: 16'd6, dly: 1, poke: -1, stray: -1, exp_last: 18'h00028};
        vecs[4] = '{base: 18'h3FFF0, cnt: 16'd5, dly: 3, poke: -1, stray: -1, exp_last: 18'h00010};
        vecs[5] = '{base: 18'h00500, cnt: 16'd4, dly: 2, poke: 3, stray: 1, exp_last: 18'h00518};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i].base, vecs[i].cnt, vecs[i].dly, vecs[i].dly, vecs[i].poke,
                     vecs[i].stray, n_req, n_done, acc_first, rdy_before, rdy_after, last_addr);
            chk($sformatf("v%0d_requests", i), n_req, vecs[i].cnt);
            chk($sformatf("v%0d_done_pulses", i), n_done, 1);
            chk($sformatf("v%0d_last_addr", i), last_addr, vecs[i].exp_last);
            @(posedge clk); #1;
        end

        // Back-pressure: first wr_done withheld, FIFO of 4 fills and stalls the stream.
        run_xfer(18'h00040, 16'd8, 2, 12, -1, -1, n_req, n_done, acc_first, rdy_before,
                 rdy_after, last_addr);
        chk("bp_accepted_when_full", acc_first, 4);
        chk("bp_ready_low_when_full", rdy_before, 0);
        chk("bp_ready_after_pop", rdy_after, 1);
        chk("bp_requests", n_req, 8);
        chk("bp_done_pulses", n_done, 1);
        chk("bp_last_addr", last_addr, 18'h00078);
        @(posedge clk); #1;

        // Zero-length transfer.
        base_addr = 18'h00200; beat_count = 16'd0; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_avail = 1'b0; saw_ready = 1'b0; dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (data_avail) saw_avail = 1'b1;
            if (in_ready) saw_ready = 1'b1;
            if (done) dones++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("zero_no_request", saw_avail, 0);
        chk("zero_no_accept", saw_ready, 0);
        chk("zero_done_pulses", dones, 1);
        chk("zero_busy_after", busy, 0);

        // Reset during ISSUE of beat 2 of 5.
        tag = tag + 8'd1;
        base_addr = 18'h00800; beat_count = 16'd5; start = 1'b1; in_valid = 1'b1;
        in_data = pat(7);
        @(posedge clk); #1;
        start = 1'b0; found = 1'b0; reqs = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            wr_done = 1'b0;
            if (data_avail) begin
                if (reqs == 1) begin
                    found = 1'b1;
                end else begin
                    wr_done = 1'b1;
                    reqs++;
                end
            end
            if (!found) begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reached_beat2", found, 1);
        chk("rst_beat2_addr", addr, 18'h00808);
        rst = 1'b1; wr_done = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("midrst");
        rst = 1'b0; in_valid = 1'b0;
        dones = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_idle", busy, 0);
        run_xfer(18'h01000, 16'd1, 2, 2, -1, -1, n_req, n_done, acc_first, rdy_before,
                 rdy_after, last_addr);
        chk("post_rst_requests", n_req, 1);
        chk("post_rst_done", n_done, 1);
        chk("post_rst_addr", last_addr, 18'h01000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
